// File: rtl/pulse_seq_pkg.sv
// Shared constants and types for the multi-channel laser pulse sequencer.
// Holds the per-channel register map, CTRL bit positions, the global control
// address used when PULSE_SEQ_SYNC_START_EN is defined, and the channel FSM states.
package pulse_seq_pkg;

   // Per-channel register offsets (reg_addr[3:0])
   localparam logic [3:0] REG_INITIAL = 4'd0;
   localparam logic [3:0] REG_HIGH    = 4'd1;
   localparam logic [3:0] REG_LOW     = 4'd2;
   localparam logic [3:0] REG_BURST   = 4'd3;
   localparam logic [3:0] REG_CTRL    = 4'd4;
   localparam logic [3:0] REG_STATUS  = 4'd5;

   // Global start/stop register (only decoded with PULSE_SEQ_SYNC_START_EN)
   localparam logic [7:0] GLOBAL_CTRL_ADDR = 8'hF0;

   // CTRL register bit positions (self-clearing command pulses)
   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_STOP_BIT  = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      INITIAL = 2'd1,
      HIGH    = 2'd2,
      LOW     = 2'd3
   } chan_state_e;

endpackage

// File: rtl/pulse_seq_channel.sv
// One sequencer channel: config registers, phase counter, pulse counter, FSM.
// A start command is registered for one cycle and enters INITIAL on the
// following edge; a stop command returns to IDLE on the edge it is sampled.
module pulse_seq_channel
   import pulse_seq_pkg::*;
#(
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   wr_en_i,
   input  logic [3:0]             reg_sel_i,
   input  logic [COUNT_WIDTH-1:0] wdata_i,
   input  logic                   start_i,
   input  logic                   stop_i,
   output logic [COUNT_WIDTH-1:0] rdata_o,
   output logic                   laser_en_o,
   output logic                   running_o
);

   localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

   logic [COUNT_WIDTH-1:0] initial_q, high_q, low_q, burst_q;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [COUNT_WIDTH-1:0] pulses_q, pulses_d;
   logic [COUNT_WIDTH-1:0] burst_lim_q, burst_lim_d;
   chan_state_e            state_q, state_d;
   logic                   start_pend_q, start_pend_d;
   logic                   laser_q, laser_d;
   logic                   running_q, running_d;

   // Counter preload for a phase: a length of 0 behaves as 1 cycle.
   function automatic logic [COUNT_WIDTH-1:0] phase_load(input logic [COUNT_WIDTH-1:0] len);
      return (len == '0) ? '0 : len - ONE;
   endfunction

   // Config register writes; phase lengths are only sampled on phase entry.
   // NOTE: the config registers are cleared by reset because their reset value
   // of zero is architecturally visible through readback.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         initial_q <= '0;
         high_q    <= '0;
         low_q     <= '0;
         burst_q   <= '0;
      end else if (wr_en_i) begin
         // NOTE: non-blocking assignments keep every flop updating from the
         // pre-edge values, regardless of statement order.
         case (reg_sel_i)
            REG_INITIAL: initial_q <= wdata_i;
            REG_HIGH:    high_q    <= wdata_i;
            REG_LOW:     low_q     <= wdata_i;
            REG_BURST:   burst_q   <= wdata_i;
            default:     ;
         endcase
      end
   end

   // FSM state, phase counter, pulse counter and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         pulses_q     <= '0;
         burst_lim_q  <= '0;
         start_pend_q <= 1'b0;
         laser_q      <= 1'b0;
         running_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pulses_q     <= pulses_d;
         burst_lim_q  <= burst_lim_d;
         start_pend_q <= start_pend_d;
         laser_q      <= laser_d;
         running_q    <= running_d;
      end
   end

   // Next-state logic: stop beats a pending start, a pending start beats phase progress.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      state_d      = state_q;
      cnt_d        = cnt_q;
      pulses_d     = pulses_q;
      burst_lim_d  = burst_lim_q;
      start_pend_d = start_i;

      if (stop_i) begin
         state_d      = IDLE;
         start_pend_d = 1'b0;
      end else if (start_pend_q) begin
         state_d     = INITIAL;
         cnt_d       = phase_load(initial_q);
         pulses_d    = '0;
         burst_lim_d = burst_q;
      end else begin
         case (state_q)
            INITIAL: begin
               if (cnt_q == '0) begin
                  state_d = HIGH;
                  cnt_d   = phase_load(high_q);
               end else begin
                  cnt_d = cnt_q - ONE;
               end
            end
            HIGH: begin
               if (cnt_q == '0) begin
                  pulses_d = pulses_q + ONE;
                  if ((burst_lim_q != '0) && (pulses_d == burst_lim_q)) begin
                     state_d = IDLE;
                  end else begin
                     state_d = LOW;
                     cnt_d   = phase_load(low_q);
                  end
               end else begin
                  cnt_d = cnt_q - ONE;
               end
            end
            LOW: begin
               if (cnt_q == '0) begin
                  state_d = HIGH;
                  cnt_d   = phase_load(high_q);
               end else begin
                  cnt_d = cnt_q - ONE;
               end
            end
            default: ;
         endcase
      end

      laser_d   = (state_d == HIGH);
      running_d = (state_d != IDLE);
   end

   // Readback of this channel's registers; CTRL and unmapped offsets read 0.
   always_comb begin
      rdata_o = '0;
      case (reg_sel_i)
         REG_INITIAL: rdata_o = initial_q;
         REG_HIGH:    rdata_o = high_q;
         REG_LOW:     rdata_o = low_q;
         REG_BURST:   rdata_o = burst_q;
         REG_STATUS:  rdata_o = {pulses_q[COUNT_WIDTH-3:0], laser_q, running_q};
         default:     ;
      endcase
   end

   assign laser_en_o = laser_q;
   assign running_o  = running_q;

endmodule

// File: rtl/pulse_seq_array.sv
// Multi-channel laser pulse sequencer: address decode, read pipeline and
// N_CHANNELS instances of pulse_seq_channel.
// Optional feature: define PULSE_SEQ_SYNC_START_EN to enable the global
// start/stop register at 0xF0 (otherwise 0xF0 is an unmapped address).
module pulse_seq_array
   import pulse_seq_pkg::*;
#(
   parameter int N_CHANNELS  = 4,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [7:0]             reg_addr,
   input  logic [COUNT_WIDTH-1:0] reg_wdata,
   input  logic                   reg_wr,
   input  logic                   reg_rd,
   output logic [COUNT_WIDTH-1:0] reg_rdata,
   output logic                   reg_rvalid,
   output logic [N_CHANNELS-1:0]  laser_en,
   output logic [N_CHANNELS-1:0]  running
);

   logic [3:0]             chan_sel, reg_sel;
   logic [N_CHANNELS-1:0]  ch_wr, ch_start, ch_stop;
   logic [COUNT_WIDTH-1:0] ch_rdata [N_CHANNELS];
   logic [COUNT_WIDTH-1:0] rd_mux;
   logic [COUNT_WIDTH-1:0] rd_stage_q, rdata_q;
   logic                   rd_stage_v_q, rvalid_q;

   assign chan_sel = reg_addr[7:4];
   assign reg_sel  = reg_addr[3:0];

   // Write decode into per-channel write enables and start/stop commands.
   always_comb begin
      ch_wr    = '0;
      ch_start = '0;
      ch_stop  = '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
         if (reg_wr && (chan_sel == 4'(i))) begin
            ch_wr[i] = 1'b1;
            if (reg_sel == REG_CTRL) begin
               ch_stop[i]  = reg_wdata[CTRL_STOP_BIT];
               ch_start[i] = reg_wdata[CTRL_START_BIT] & ~reg_wdata[CTRL_STOP_BIT];
            end
         end
`ifdef PULSE_SEQ_SYNC_START_EN
         if (reg_wr && (reg_addr == GLOBAL_CTRL_ADDR)) begin
            if (reg_wdata[COUNT_WIDTH-1]) ch_stop[i]  = reg_wdata[i];
            else                          ch_start[i] = reg_wdata[i];
         end
`endif
      end
   end

   // Read mux; channels beyond N_CHANNELS and unmapped offsets return 0.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
         if (chan_sel == 4'(i)) rd_mux = ch_rdata[i];
      end
`ifdef PULSE_SEQ_SYNC_START_EN
      if (reg_addr == GLOBAL_CTRL_ADDR) begin
         for (int i = 0; i < N_CHANNELS; i++) rd_mux[i] = running[i];
      end
`endif
   end

   // Two-stage read pipeline: data captured on the sampling edge (pre-write
   // value on a simultaneous write) and presented after the following edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_stage_q   <= '0;
         rd_stage_v_q <= 1'b0;
         rdata_q      <= '0;
         rvalid_q     <= 1'b0;
      end else begin
         rd_stage_v_q <= reg_rd;
         if (reg_rd) rd_stage_q <= rd_mux;
         rvalid_q <= rd_stage_v_q;
         rdata_q  <= rd_stage_v_q ? rd_stage_q : '0;
      end
   end

   assign reg_rdata  = rdata_q;
   assign reg_rvalid = rvalid_q;

   for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
      pulse_seq_channel #(
         .COUNT_WIDTH (COUNT_WIDTH)
      ) u_chan (
         .clk        (clk),
         .reset_n    (reset_n),
         .wr_en_i    (ch_wr[g]),
         .reg_sel_i  (reg_sel),
         .wdata_i    (reg_wdata),
         .start_i    (ch_start[g]),
         .stop_i     (ch_stop[g]),
         .rdata_o    (ch_rdata[g]),
         .laser_en_o (laser_en[g]),
         .running_o  (running[g])
      );
   end

endmodule

// File: tb/tb_pulse_seq_array.sv
// Directed testbench for pulse_seq_array (4 channels, 32-bit counts).
// Expected values are hand-derived from the sequencer timing rules.
module tb_pulse_seq_array;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  reg_addr = '0;
   logic [31:0] reg_wdata = '0;
   logic        reg_wr = 1'b0;
   logic        reg_rd = 1'b0;
   logic [31:0] reg_rdata;
   logic        reg_rvalid;
   logic [3:0]  laser_en;
   logic [3:0]  running;

   int n_checks = 0;
   int n_fail   = 0;

   pulse_seq_array #(
      .N_CHANNELS  (4),
      .COUNT_WIDTH (32)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_wr     (reg_wr),
      .reg_rd     (reg_rd),
      .reg_rdata  (reg_rdata),
      .reg_rvalid (reg_rvalid),
      .laser_en   (laser_en),
      .running    (running)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge and settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      reg_addr  = a;
      reg_wdata = d;
      reg_wr    = 1'b1;
      tick();
      reg_wr = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
      reg_addr = a;
      reg_rd   = 1'b1;
      tick();
      reg_rd = 1'b0;
      check({tag, "_rv_early"}, 32'(reg_rvalid), 32'd0);
      tick();
      check({tag, "_rv"}, 32'(reg_rvalid), 32'd1);
      check({tag, "_data"}, reg_rdata, exp);
      tick();
      check({tag, "_rv_once"}, 32'(reg_rvalid), 32'd0);
   endtask

   // Channel 0 with INITIAL=4 HIGH=2 LOW=3: high after edges E+5,E+6, period 5.
   function automatic logic exp_laser0(input int k);
      return (k >= 5) && (((k - 5) % 5) < 2);
   endfunction

   task automatic check_ch0_run(input string tag);
      for (int k = 1; k <= 16; k++) begin
         tick();
         check($sformatf("%s_laser_k%0d", tag, k), 32'(laser_en[0]), 32'(exp_laser0(k)));
         check($sformatf("%s_run_k%0d", tag, k), 32'(running[0]), 32'd1);
      end
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_laser", 32'(laser_en), 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_rvalid", 32'(reg_rvalid), 32'd0);
      check("rst_rdata", reg_rdata, 32'd0);
      reset_n = 1'b1;
      tick();
      rd(8'h00, 32'd0, "rst_cfg");

      // Scenario 1: ch0 INITIAL=4 HIGH=2 LOW=3 BURST=0
      wr(8'h00, 32'd4);
      wr(8'h01, 32'd2);
      wr(8'h02, 32'd3);
      wr(8'h03, 32'd0);
      wr(8'h04, 32'd1);
      check("s1_pending_run", 32'(running[0]), 32'd0);
      check_ch0_run("s1");

      // Scenario 2: ch1 INITIAL=1 HIGH=3 LOW=1 BURST=2
      wr(8'h10, 32'd1);
      wr(8'h11, 32'd3);
      wr(8'h12, 32'd1);
      wr(8'h13, 32'd2);
      wr(8'h14, 32'd1);
      for (int k = 1; k <= 10; k++) begin
         tick();
         check($sformatf("s2_laser_k%0d", k), 32'(laser_en[1]),
               32'(((k >= 2) && (k <= 4)) || ((k >= 6) && (k <= 8))));
         check($sformatf("s2_run_k%0d", k), 32'(running[1]), 32'(k <= 8));
      end
      rd(8'h15, 32'h0000_0008, "s2_status");

      // Scenario 3: stop ch0 mid-HIGH, then restart
      wr(8'h04, 32'd1);
      repeat (5) tick();
      check("s3_midhigh", 32'(laser_en[0]), 32'd1);
      wr(8'h04, 32'd2);
      check("s3_stop_laser", 32'(laser_en[0]), 32'd0);
      check("s3_stop_run", 32'(running[0]), 32'd0);
      rd(8'h05, 32'd0, "s3_status");
      wr(8'h04, 32'd1);
      check_ch0_run("s3_restart");

      // Scenario 4: ch2 with all-zero registers toggles every cycle
      wr(8'h24, 32'd1);
      for (int k = 1; k <= 6; k++) begin
         tick();
         check($sformatf("s4_laser_k%0d", k), 32'(laser_en[2]), 32'((k >= 2) && (k % 2 == 0)));
         check($sformatf("s4_run_k%0d", k), 32'(running[2]), 32'd1);
      end
      wr(8'h24, 32'd2);
      check("s4_stop_run", 32'(running[2]), 32'd0);
      wr(8'h34, 32'd3);
      tick();
      check("s4_startstop_run1", 32'(running[3]), 32'd0);
      tick();
      check("s4_startstop_run2", 32'(running[3]), 32'd0);
      check("s4_startstop_laser", 32'(laser_en[3]), 32'd0);

      // Scenario 5: readback, unmapped reads, simultaneous read/write
      wr(8'h01, 32'h40);
      rd(8'h01, 32'h40, "s5_high");
      rd(8'hE1, 32'd0, "s5_unmapped_ch");
      rd(8'h41, 32'd0, "s5_absent_ch");
      rd(8'h04, 32'd0, "s5_ctrl_wo");
      reg_addr  = 8'h00;
      reg_wdata = 32'd7;
      reg_wr    = 1'b1;
      reg_rd    = 1'b1;
      tick();
      reg_wr = 1'b0;
      reg_rd = 1'b0;
      tick();
      check("s5_rw_rv", 32'(reg_rvalid), 32'd1);
      check("s5_rw_pre", reg_rdata, 32'd4);
      rd(8'h00, 32'd7, "s5_rw_post");

      // Scenario 6: global control register at 0xF0
      wr(8'h04, 32'd2);
      check("s6_all_idle", 32'(running), 32'd0);
      wr(8'hF0, 32'h0000_0005);
      check("s6_pending", 32'(running), 32'd0);
      tick();
`ifdef PULSE_SEQ_SYNC_START_EN
      check("s6_sync_start", 32'(running), 32'h5);
      rd(8'hF0, 32'h5, "s6_global_rd");
      wr(8'hF0, 32'h8000_0005);
      check("s6_sync_stop", 32'(running), 32'd0);
`else
      check("s6_ignored", 32'(running), 32'd0);
      rd(8'hF0, 32'd0, "s6_global_rd");
`endif

      // Scenario 7: asynchronous reset mid-pulse (ch0 INITIAL=7, HIGH=0x40)
      wr(8'h04, 32'd1);
      repeat (9) tick();
      check("s7_before_laser", 32'(laser_en[0]), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("s7_async_laser", 32'(laser_en), 32'd0);
      check("s7_async_run", 32'(running), 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      rd(8'h00, 32'd0, "s7_cfg_cleared");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pulse_seq_array.md
Name: pulse_seq_array

Overview:
- Multi-channel laser pulse sequencer driving `laser_en`.
- Parametrised successor to the fixed per-channel pulse sequencer inside fx2_timetag.
- Programmed through a generic register port fed by the FX2 command decoder. Each channel runs initial delay, then alternating high/low phases.
- New over the previous generation: channel count and count width are parametrised, with per-channel burst length, readback, and immediate stop.

Parameters:
- N_CHANNELS, 4, number of sequencer channels (1..15).
- COUNT_WIDTH, 32, width of all phase-length and burst registers and counters.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- reg_addr  in  8  [7:4] channel, [3:0] register.
- reg_wdata  in  COUNT_WIDTH  write data.
- reg_wr  in  1  write strobe, one cycle per write.
- reg_rd  in  1  read strobe.
- reg_rdata  out  COUNT_WIDTH  read data.
- reg_rvalid  out  1  read data valid, one cycle.
- laser_en  out  N_CHANNELS  pulse outputs, registered.
- running  out  N_CHANNELS  channel not IDLE.

Behaviour:
- Reset: all outputs 0, every channel IDLE, all config registers 0.
- Register map per channel (reg_addr[3:0]):
  - 0 INITIAL
  - 1 HIGH
  - 2 LOW
  - 3 BURST (0 = infinite)
  - 4 CTRL: write-only, bit0 start, bit1 stop; self-clearing pulses, not stored.
  - 5 STATUS: bit0 running, bit1 laser_en, bits[COUNT_WIDTH-1:2] low bits of pulses completed since start.
- Unmapped addresses and channels >= N_CHANNELS: writes ignored, reads return 0 with reg_rvalid.
- Read latency: reg_rd sampled at edge E gives reg_rdata/reg_rvalid valid after edge E+1. reg_rvalid is high for exactly one cycle.
- State machine per channel: IDLE -> INITIAL -> HIGH -> LOW -> HIGH ... laser_en=1 only in HIGH.
- Phase length: each phase lasts exactly max(value,1) cycles. A zero register is treated as 1.
- Timing: start written at edge E gives INITIAL from edge E+1. laser_en rises after edge E+1+INITIAL, stays high HIGH cycles, then low LOW cycles.
- Config registers are sampled when a phase is entered. Writes during a phase affect the next entry of that phase only.
- Burst: with BURST=N>0, the channel returns to IDLE at the end of the Nth HIGH phase. It never enters the trailing LOW. laser_en falls and running falls on the same edge.
- Stop: stop at edge E sets IDLE, laser_en=0 and running=0 after edge E. Any partial pulse is truncated.
- Start while running restarts from INITIAL and clears the pulse count.
- Start and stop set in the same write: stop wins.
- Pulse counter wraps modulo 2^(COUNT_WIDTH-2).
- reg_wr and reg_rd in the same cycle: both serviced; read returns pre-write value.
- Reset asserted mid-operation: immediate IDLE, all outputs 0 asynchronously.

Optional Feature:
- Macro: PULSE_SEQ_SYNC_START_EN.
- Defined: address 0xF0 is a global control register. A write where reg_wdata[N_CHANNELS-1:0] is the channel mask and reg_wdata[COUNT_WIDTH-1] = 0 starts all masked channels on the same edge. With reg_wdata[COUNT_WIDTH-1] = 1, it stops them. Reads of 0xF0 return the running vector.
- Undefined: 0xF0 behaves as an unmapped address (writes ignored, reads return 0).

Decomposition:
- Package pulse_seq_pkg holds:
  - register offset constants (REG_INITIAL..REG_STATUS, GLOBAL_CTRL_ADDR);
  - CTRL bit positions;
  - channel state enum typedef (IDLE, INITIAL, HIGH, LOW).
- Sub-module pulse_seq_channel holds one channel's config registers, phase counter, burst counter and FSM. It is instantiated N_CHANNELS times by a generate loop.
- Top level does address decode, read mux and the optional global control.

Test Plan:
- Ch0 INITIAL=4, HIGH=2, LOW=3, BURST=0, start at edge E -> laser_en[0] high after edges E+5..E+6, low for 3 cycles, period 5, running[0]=1 throughout.
- Ch1 INITIAL=1, HIGH=3, LOW=1, BURST=2 -> exactly two 3-cycle pulses. running[1] and laser_en[1] fall together. STATUS reads running=0, count=2.
- Stop written to ch0 mid-HIGH -> laser_en[0]=0 after the next edge. STATUS bit0=0. Restart reproduces the scenario-1 timing exactly.
- Zero-length registers (all 0) -> 1-cycle initial, then alternating 1-cycle high/low (toggle every cycle). CTRL with start|stop -> channel stays IDLE.
- Read of ch0 HIGH=0x40 then unmapped ch 0xE -> rdata 0x40 one cycle after reg_rd, then 0, each with a single reg_rvalid pulse.
- With PULSE_SEQ_SYNC_START_EN: write 0xF0 mask 4'b0101 -> ch0 and ch2 enter INITIAL on the same edge. Without the macro, the same write leaves all channels IDLE.
